// File: rtl/adc_capture_fifo_if.sv
// Avalon-MM slave bus bundle for the ADC capture engine register file.
interface adc_capture_fifo_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/adc_capture_fifo.sv
// Multi-channel ADC capture: decimated sampling, level trigger, sample FIFO
// drained over Avalon-MM, level IRQ on completion or overflow.
module adc_capture_fifo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned DECIM_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS*DATA_W-1:0]   adc_data,
    adc_capture_fifo_if.slave            bus,
    output logic                         irq
);
    localparam int unsigned SW    = CHANNELS * DATA_W;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned REM_W = 17;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_CFG    = 3'd3;
    localparam logic [2:0] A_DECIM  = 3'd4;
    localparam logic [2:0] A_LEVEL  = 3'd5;
    localparam logic [2:0] A_COUNT  = 3'd6;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t              state;
    logic [SW-1:0]       s0, s1;
    logic [DECIM_W-1:0]  dcnt;
    logic [REM_W-1:0]    remaining;
    logic                ovf, done;

    logic                trig_en, trig_edge, irq_en;
    logic [7:0]          trig_ch;
    logic [DECIM_W-1:0]  decim;
    logic [DATA_W-1:0]   level;
    logic [15:0]         count;

    logic [SW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       fill;

    logic                wr_ctrl_c, start_c, flush_c, sts_wr_c, pop_c;
    logic                empty_c, full_c, busy_c, tick_c, hit_c, push_c, accept_c;
    logic                unused_c;
    logic [DATA_W-1:0]   trig_s0_c, trig_s1_c;
    logic [REM_W-1:0]    reload_c;
    logic [31:0]         status_c;

    assign wr_ctrl_c = bus.write && (bus.address == A_CTRL);
    assign start_c   = wr_ctrl_c && bus.writedata[0];
    assign flush_c   = wr_ctrl_c && (bus.writedata[0] || bus.writedata[1]);
    assign sts_wr_c  = bus.write && (bus.address == A_STATUS);
    assign empty_c   = (fill == '0);
    assign full_c    = (fill == LW'(DEPTH));
    assign busy_c    = (state == ARMED) || (state == CAPTURE);
    assign pop_c     = bus.read && (bus.address == A_DATA) && !empty_c;
    assign tick_c    = (dcnt >= decim);
    assign reload_c  = (count == 16'd0) ? REM_W'(DEPTH) : REM_W'(count);
    assign status_c  = {16'(fill), 11'd0, done, busy_c, ovf, full_c, empty_c};
    assign unused_c  = ^bus.writedata;

    // Out-of-range trigger channel falls back to channel 0.
    always_comb begin
        trig_s0_c = s0[DATA_W-1:0];
        trig_s1_c = s1[DATA_W-1:0];
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (trig_ch == 8'(c)) begin
                trig_s0_c = s0[c*DATA_W +: DATA_W];
                trig_s1_c = s1[c*DATA_W +: DATA_W];
            end
        end
    end

    assign hit_c = trig_edge ? ((trig_s1_c >= level) && (level > trig_s0_c))
                             : ((trig_s1_c < level) && (level <= trig_s0_c));

    // The triggering tick already stores its sample.
    assign push_c   = tick_c && !start_c &&
                      ((state == CAPTURE) || ((state == ARMED) && hit_c));
    assign accept_c = push_c && !flush_c && (!full_c || pop_c);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0   <= '0;
            s1   <= '0;
            dcnt <= '0;
        end else begin
            s0   <= adc_data;
            s1   <= s0;
            dcnt <= (start_c || tick_c) ? '0 : dcnt + DECIM_W'(1);
        end
    end

    // Configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_en   <= 1'b0;
            trig_edge <= 1'b0;
            irq_en    <= 1'b0;
            trig_ch   <= '0;
            decim     <= '0;
            level     <= '0;
            count     <= '0;
        end else if (bus.write) begin
            case (bus.address)
                A_CFG: begin
                    trig_en   <= bus.writedata[0];
                    trig_edge <= bus.writedata[1];
                    irq_en    <= bus.writedata[2];
                    trig_ch   <= bus.writedata[15:8];
                end
                A_DECIM: decim <= bus.writedata[DECIM_W-1:0];
                A_LEVEL: level <= bus.writedata[DATA_W-1:0];
                A_COUNT: count <= bus.writedata[15:0];
                default: ;
            endcase
        end
    end

    // Capture FSM with sticky flags; start restarts from any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else if (start_c) begin
            state     <= trig_en ? ARMED : CAPTURE;
            remaining <= reload_c;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (push_c && full_c && !pop_c && !flush_c)
                ovf <= 1'b1;
            else if (sts_wr_c && bus.writedata[2])
                ovf <= 1'b0;

            if (push_c && (remaining == REM_W'(1)))
                done <= 1'b1;
            else if (sts_wr_c && bus.writedata[4])
                done <= 1'b0;

            case (state)
                ARMED, CAPTURE: begin
                    if (push_c) begin
                        remaining <= remaining - REM_W'(1);
                        state     <= (remaining == REM_W'(1)) ? DONE : CAPTURE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept_c)
            mem[wr_ptr] <= s0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (flush_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (accept_c)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)
                rd_ptr <= rd_ptr + AW'(1);
            fill <= fill + LW'(accept_c) - LW'(pop_c);
        end
    end

    // Read port, latency 1; DATA returns the head before any same-cycle flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else if (bus.read) begin
            case (bus.address)
                A_DATA:   bus.readdata <= empty_c ? 32'd0 : 32'(mem[rd_ptr]);
                A_STATUS: bus.readdata <= status_c;
                A_CFG:    bus.readdata <= {16'd0, trig_ch, 5'd0, irq_en, trig_edge, trig_en};
                A_DECIM:  bus.readdata <= 32'(decim);
                A_LEVEL:  bus.readdata <= 32'(level);
                A_COUNT:  bus.readdata <= {16'd0, count};
                default:  bus.readdata <= 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= irq_en && (done || ovf);
    end
endmodule

// File: tb/tb_adc_capture_fifo.sv
// Directed bench for adc_capture_fifo: reset, capture, triggers, decimation,
// overflow/IRQ, concurrent drain and mid-capture reset.
module tb_adc_capture_fifo;
    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_CFG    = 3'd3;
    localparam logic [2:0] A_DECIM  = 3'd4;
    localparam logic [2:0] A_LEVEL  = 3'd5;
    localparam logic [2:0] A_COUNT  = 3'd6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] adc_data = '0;
    logic        irq;
    logic [31:0] d;
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;

    adc_capture_fifo_if bus();

    adc_capture_fifo #(
        .DATA_W(8), .CHANNELS(2), .DEPTH(4), .DECIM_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .adc_data(adc_data),
        .bus(bus),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.address = a; bus.writedata = v; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.address = a; bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        v = bus.readdata;
    endtask

    task automatic rdchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(tag, v, exp);
    endtask

    initial begin
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        chk("rst_irq", 32'(irq), 32'd0);
        for (int a = 0; a < 8; a++)
            rdchk($sformatf("rst_addr%0d", a), 3'(a), (a == 1) ? 32'd1 : 32'd0);

        // Untriggered capture of a ramp, DECIM=0, COUNT=4
        wr(A_COUNT, 32'd4);
        @(negedge clk);
        bus.address = A_CTRL; bus.writedata = 32'd1; bus.write = 1'b1; adc_data = 16'h1110;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            bus.write = 1'b0;
            adc_data = {8'(8'h11 + 2 * k), 8'(8'h10 + 2 * k)};
        end
        rdchk("t2_status_full", A_STATUS, 32'h0004_0012);
        rdchk("t2_pop0", A_DATA, 32'h0000_1110);
        rdchk("t2_pop1", A_DATA, 32'h0000_1312);
        rdchk("t2_pop2", A_DATA, 32'h0000_1514);
        rdchk("t2_pop3", A_DATA, 32'h0000_1716);
        rdchk("t2_pop_empty", A_DATA, 32'd0);
        rdchk("t2_status_end", A_STATUS, 32'h0000_0011);
        chk("t2_irq_off", 32'(irq), 32'd0);

        // Rising trigger on ch0 at LEVEL=0x80
        wr(A_STATUS, 32'h14);
        wr(A_LEVEL, 32'h80);
        wr(A_CFG, 32'h1);
        wr(A_COUNT, 32'd2);
        adc_data = 16'h007F;
        wr(A_CTRL, 32'd1);
        repeat (3) @(negedge clk);
        rdchk("t3_armed_nopush", A_STATUS, 32'h0000_0009);
        @(negedge clk); adc_data = 16'h0180;
        @(negedge clk); adc_data = 16'h0281;
        @(negedge clk); adc_data = 16'h0382;
        repeat (3) @(negedge clk);
        rdchk("t3_status", A_STATUS, 32'h0002_0010);
        rdchk("t3_first", A_DATA, 32'h0000_0180);
        rdchk("t3_second", A_DATA, 32'h0000_0281);

        // Falling trigger on ch1, COUNT=1
        wr(A_CFG, 32'h0103);
        wr(A_COUNT, 32'd1);
        adc_data = 16'h8000;
        wr(A_CTRL, 32'd1);
        repeat (2) @(negedge clk);
        rdchk("t3f_armed", A_STATUS, 32'h0000_0009);
        @(negedge clk); adc_data = 16'h7F05;
        repeat (4) @(negedge clk);
        rdchk("t3f_status", A_STATUS, 32'h0001_0010);
        rdchk("t3f_data", A_DATA, 32'h0000_7F05);

        // Decimation DECIM=3, COUNT=3
        wr(A_STATUS, 32'h14);
        wr(A_CFG, 32'h0);
        wr(A_DECIM, 32'd3);
        wr(A_COUNT, 32'd3);
        @(negedge clk);
        bus.address = A_CTRL; bus.writedata = 32'd1; bus.write = 1'b1; adc_data = 16'h0A00;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (k == 12) chk("t4_busy_mid", bus.readdata, 32'h0002_0008);
            if (k == 14) chk("t4_done", bus.readdata, 32'h0003_0010);
            bus.write = 1'b0;
            bus.address = A_STATUS;
            bus.read = (k == 11) || (k == 13);
            adc_data = 16'(16'h0A00 + k);
        end
        bus.read = 1'b0;
        rdchk("t4_pop0", A_DATA, 32'h0000_0A03);
        rdchk("t4_pop1", A_DATA, 32'h0000_0A07);
        rdchk("t4_pop2", A_DATA, 32'h0000_0A0B);
        rdchk("t4_status_end", A_STATUS, 32'h0000_0011);

        // Overflow with DEPTH=4, COUNT=6, irq enabled
        wr(A_STATUS, 32'h14);
        wr(A_CFG, 32'h4);
        wr(A_DECIM, 32'd0);
        wr(A_COUNT, 32'd6);
        adc_data = 16'h5555;
        wr(A_CTRL, 32'd1);
        repeat (10) @(negedge clk);
        rdchk("t5_status_ovf", A_STATUS, 32'h0004_0016);
        chk("t5_irq_set", 32'(irq), 32'd1);
        wr(A_STATUS, 32'h14);
        repeat (2) @(negedge clk);
        chk("t5_irq_clr", 32'(irq), 32'd0);
        rdchk("t5_status_w1c", A_STATUS, 32'h0004_0002);
        rdchk("t5_pop", A_DATA, 32'h0000_5555);
        rdchk("t5_level3", A_STATUS, 32'h0003_0000);
        wr(A_CTRL, 32'd2);
        rdchk("t5_flush", A_STATUS, 32'h0000_0001);

        // Drain on every tick keeps the level at most 1
        wr(A_CFG, 32'h0);
        wr(A_DECIM, 32'd3);
        wr(A_COUNT, 32'd0);
        adc_data = 16'h6666;
        wr(A_CTRL, 32'd1);
        for (int i = 0; i < 7; i++) begin
            rd(A_DATA, d);
            if (d == 32'h6666) pops++;
            chk("t6_pop_value", 32'((d == 32'd0) || (d == 32'h6666)), 32'd1);
            rd(A_STATUS, d);
            chk("t6_level_le1", 32'(d[31:16] <= 16'd1), 32'd1);
        end
        chk("t6_pop_count", 32'(pops), 32'd4);
        rdchk("t6_status_end", A_STATUS, 32'h0000_0011);

        // Reset asserted mid-capture
        wr(A_DECIM, 32'd100);
        wr(A_CTRL, 32'd1);
        repeat (3) @(negedge clk);
        rdchk("t6_busy", A_STATUS, 32'h0000_0009);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_irq", 32'(irq), 32'd0);
        chk("t6_rst_readdata", bus.readdata, 32'd0);
        reset_n = 1'b1;
        rdchk("t6_rst_status", A_STATUS, 32'h0000_0001);
        rdchk("t6_rst_decim", A_DECIM, 32'd0);
        rdchk("t6_rst_cfg", A_CFG, 32'd0);
        rdchk("t6_rst_count", A_COUNT, 32'd0);
        repeat (20) @(negedge clk);
        rdchk("t6_idle", A_STATUS, 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
